aoc1_cmd_parser: RTL and testbench

- Front-end decoder for the day-1 dial datapath.
- Converts the raw ASCII puzzle byte stream ("L68\nR48\n...") into one rotation command per line: a direction bit plus a binary magnitude.
- Output feeds the dial counter's en/dir/rot inputs through a valid/ready handshake.
- Upstream is a byte streamer (UART/ROM) with valid/ready and an end-of-input marker.

---
 rtl/aoc1_cmd_parser.sv | 182 ++++++++++++++++++
 tb/tb_aoc1_cmd_parser.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/aoc1_cmd_parser.sv
// ASCII rotation-command parser: turns "L68\nR48\n..." into (dir, rot) commands over valid/ready.
// Optional AOC1_PARSE_ERR_EN adds strict malformed-input detection with parse_err / err_count.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module aoc1_cmd_parser #(
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_dir,
    output logic [DATA_WIDTH-1:0] cmd_rot,
    output logic [DATA_WIDTH-1:0] cmd_count,
    output logic                  overflow,
    output logic                  done
`ifdef AOC1_PARSE_ERR_EN
    ,
    output logic                  parse_err,
    output logic [DATA_WIDTH-1:0] err_count
`endif
);

    localparam int AW = DATA_WIDTH + 4;

    typedef enum logic [2:0] {
        S_DIR,
        S_NUM,
        S_EMIT,
        S_SKIP,
        S_DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] acc;
    logic                  has_dig;
    logic                  dir;
    logic                  last_pend;

    logic                  take;
    logic                  is_ws;
    logic                  is_digit;
    logic                  is_l;
    logic                  is_r;
    logic [AW-1:0]         acc_wide;
    logic                  sat;
    logic [DATA_WIDTH-1:0] acc_next;
    logic                  emit_ok;
    logic                  to_skip;
    logic                  malformed;

    assign byte_ready = (state != S_EMIT) && !done;
    assign take       = byte_valid && byte_ready;

    always_comb begin
        is_ws    = (byte_data == 8'h0A) || (byte_data == 8'h0D) || (byte_data == 8'h20);
        is_digit = (byte_data >= 8'h30) && (byte_data <= 8'h39);
        is_l     = (byte_data == 8'h4C);
        is_r     = (byte_data == 8'h52);
        // acc*10 + digit at four extra bits, so any carry out marks saturation
        acc_wide = (AW'(acc) << 3) + (AW'(acc) << 1) + AW'(byte_data[3:0]);
        sat      = |acc_wide[AW-1:DATA_WIDTH];
        acc_next = sat ? '1 : acc_wide[DATA_WIDTH-1:0];
`ifdef AOC1_PARSE_ERR_EN
        emit_ok   = has_dig && is_ws;
        to_skip   = !is_ws;
        malformed = take && (((state == S_DIR) && !is_ws && !is_l && !is_r) ||
                             ((state == S_NUM) && !is_digit && (!is_ws || !has_dig)));
`else
        emit_ok   = has_dig;
        to_skip   = 1'b0;
        malformed = 1'b0;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_DIR;
            acc       <= '0;
            has_dig   <= 1'b0;
            dir       <= 1'b0;
            last_pend <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_dir   <= 1'b0;
            cmd_rot   <= '0;
            cmd_count <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_DIR: begin
                    if (take) begin
                        if (byte_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (is_l || is_r) begin
                            dir     <= is_l;
                            acc     <= '0;
                            has_dig <= 1'b0;
                            state   <= S_NUM;
                        end else if (malformed) begin
                            state <= S_SKIP;
                        end
                    end
                end
                S_NUM: begin
                    if (take) begin
                        if (is_digit) begin
                            acc     <= acc_next;
                            has_dig <= 1'b1;
                            if (sat)
                                overflow <= 1'b1;
                            if (byte_last) begin
                                cmd_rot   <= acc_next;
                                cmd_dir   <= dir;
                                cmd_valid <= 1'b1;
                                last_pend <= 1'b1;
                                state     <= S_EMIT;
                            end
                        end else if (emit_ok) begin
                            cmd_rot   <= acc;
                            cmd_dir   <= dir;
                            cmd_valid <= 1'b1;
                            last_pend <= byte_last;
                            state     <= S_EMIT;
                        end else if (byte_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= to_skip ? S_SKIP : S_DIR;
                        end
                    end
                end
                S_EMIT: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd_count <= cmd_count + DATA_WIDTH'(1);
                        if (last_pend) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_DIR;
                        end
                    end
                end
                // Rest of a malformed line is discarded up to the next whitespace
                S_SKIP: begin
                    if (take) begin
                        if (byte_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (is_ws) begin
                            state <= S_DIR;
                        end
                    end
                end
                S_DONE: state <= S_DONE;
                default: state <= S_DIR;
            endcase
        end
    end

`ifdef AOC1_PARSE_ERR_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parse_err <= 1'b0;
            err_count <= '0;
        end else if (malformed) begin
            parse_err <= 1'b1;
            if (err_count != '1)
                err_count <= err_count + DATA_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_aoc1_cmd_parser.sv
// Directed self-checking bench for aoc1_cmd_parser (DATA_WIDTH = 16).
module tb_aoc1_cmd_parser;

    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_last;
    logic          byte_ready;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [DW-1:0] cmd_rot;
    logic [DW-1:0] cmd_count;
    logic          overflow;
    logic          done;
`ifdef AOC1_PARSE_ERR_EN
    logic          parse_err;
    logic [DW-1:0] err_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    aoc1_cmd_parser #(.DATA_WIDTH(DW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_rot    (cmd_rot),
        .cmd_count  (cmd_count),
        .overflow   (overflow),
        .done       (done)
`ifdef AOC1_PARSE_ERR_EN
        ,
        .parse_err  (parse_err),
        .err_count  (err_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        byte_last  = last;
        while (!byte_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("send_ready_timeout", {31'd0, byte_ready}, 32'd1);
        @(negedge clock);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_on_final);
        for (int i = 0; i < s.len(); i++)
            send(s[i], last_on_final && (i == s.len() - 1));
    endtask

    task automatic chk_cmd(input string tag, input logic d, input logic [31:0] r);
        chk({tag, "_valid"}, {31'd0, cmd_valid}, 32'd1);
        chk({tag, "_dir"},   {31'd0, cmd_dir},   {31'd0, d});
        chk({tag, "_rot"},   {16'd0, cmd_rot},   r);
    endtask

    initial begin
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        cmd_ready  = 1'b1;
        repeat (2) @(negedge clock);

        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_cmd_rot",   {16'd0, cmd_rot},   32'd0);
        chk("rst_cmd_count", {16'd0, cmd_count}, 32'd0);
        chk("rst_overflow",  {31'd0, overflow},  32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd1);
        reset_n = 1'b1;
        @(negedge clock);

        // Two lines, cmd_ready held high: valid appears the cycle after '\n'
        send_str("L68\n", 1'b0);
        chk_cmd("l68", 1'b1, 32'd68);
        send_str("R48\n", 1'b0);
        chk_cmd("r48", 1'b0, 32'd48);
        @(negedge clock);
        chk("r48_valid_drop", {31'd0, cmd_valid}, 32'd0);
        chk("count_2",        {16'd0, cmd_count}, 32'd2);

        // Backpressure: command and byte_ready=0 held while cmd_ready is low
        cmd_ready = 1'b0;
        send_str("R1000\n", 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk_cmd("hold", 1'b0, 32'd1000);
            chk("hold_byte_ready", {31'd0, byte_ready}, 32'd0);
            @(negedge clock);
        end
        cmd_ready = 1'b1;
        @(negedge clock);
        chk("hold_valid_drop", {31'd0, cmd_valid}, 32'd0);
        chk("count_3",         {16'd0, cmd_count}, 32'd3);

        // Saturation to 65535 with sticky overflow
        send_str("R70000\n", 1'b0);
        chk_cmd("sat", 1'b0, 32'd65535);
        chk("sat_overflow", {31'd0, overflow}, 32'd1);
        send_str("L5\n", 1'b0);
        chk_cmd("after_sat", 1'b1, 32'd5);
        chk("sticky_overflow", {31'd0, overflow}, 32'd1);

        send_str("R0\n", 1'b0);
        chk_cmd("zero", 1'b0, 32'd0);

        // Malformed line yields no command; only (0,7) follows
        for (int i = 0; i < 4; i++) begin
            send_str(i == 0 ? "L" : i == 1 ? "X" : i == 2 ? "3" : "\n", 1'b0);
            chk("bad_line_no_cmd", {31'd0, cmd_valid}, 32'd0);
        end
        send_str("R7\n", 1'b0);
        chk_cmd("r7", 1'b0, 32'd7);
`ifdef AOC1_PARSE_ERR_EN
        chk("err_count", {16'd0, err_count}, 32'd1);
        chk("parse_err", {31'd0, parse_err}, 32'd1);
`endif
        @(negedge clock);
        chk("count_7", {16'd0, cmd_count}, 32'd7);

        // Whitespace-padded line, CR acts as terminator
        send_str("\r\n  L5\r", 1'b0);
        chk_cmd("ws_l5", 1'b1, 32'd5);
        send_str("\n", 1'b0);
        chk("count_8", {16'd0, cmd_count}, 32'd8);

        // Reset in the middle of "R12" discards it
        send_str("R12", 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_count",    {16'd0, cmd_count}, 32'd0);
        chk("mid_rst_valid",    {31'd0, cmd_valid}, 32'd0);
        chk("mid_rst_overflow", {31'd0, overflow},  32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        send_str("R3\n", 1'b0);
        chk_cmd("r3", 1'b0, 32'd3);
        @(negedge clock);
        chk("count_after_rst", {16'd0, cmd_count}, 32'd1);

        // byte_last on a digit: emit, then done forever
        send_str("L99", 1'b1);
        chk_cmd("l99", 1'b1, 32'd99);
        chk("l99_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("l99_not_done",   {31'd0, done},       32'd0);
        @(negedge clock);
        chk("done",           {31'd0, done},       32'd1);
        chk("done_valid",     {31'd0, cmd_valid},  32'd0);
        chk("done_count",     {16'd0, cmd_count},  32'd2);
        byte_valid = 1'b1;
        byte_data  = 8'h52;
        repeat (4) @(negedge clock);
        byte_valid = 1'b0;
        chk("done_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("done_sticky",     {31'd0, done},       32'd1);
        chk("done_no_cmd",     {31'd0, cmd_valid},  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
